// File: rtl/pulse_train_pkg.sv
// rtl/pulse_train_pkg.sv - shared types and constants for the pulse-train generator
package pulse_train_pkg;

  localparam int OVR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pulse_width_timer.sv
// rtl/pulse_width_timer.sv - loadable down-counter with zero flag, shared by HIGH and LOW phases
module pulse_width_timer #(
  parameter int WidthW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [WidthW-1:0] load_val_i,
  output logic              zero_o
);

  localparam logic [WidthW-1:0] ONE = WidthW'(1);

  logic [WidthW-1:0] cnt_q, cnt_d;

  // Holds at zero instead of wrapping; the FSM reloads it on each phase change.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - non-retriggering programmable burst of high/low pulses
// Optional overrun counter port and logic: define PULSE_TRAIN_OVERRUN_CNT_EN.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int WidthW = 16,
  parameter int CountW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              enable,
  input  logic [WidthW-1:0] high_width,
  input  logic [WidthW-1:0] low_width,
  input  logic [CountW-1:0] pulse_count,
  input  logic              overrun_clr,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic              overrun
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] overrun_cnt
`endif
);

  localparam logic [WidthW-1:0] W_ONE = WidthW'(1);
  localparam logic [CountW-1:0] C_ONE = CountW'(1);

  state_e            state_q, state_d;
  logic [CountW-1:0] rem_q, rem_d;
  logic [WidthW-1:0] hw_q, hw_d, lw_q, lw_d;
  logic              out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic              overrun_q;
  logic              tmr_load, tmr_zero;
  logic [WidthW-1:0] tmr_val;
  logic              ovr_hit;

  // Timer load value: width-1, with a zero width clamped to a single cycle.
  function automatic logic [WidthW-1:0] width_m1(input logic [WidthW-1:0] w);
    return (w == '0) ? '0 : w - W_ONE;
  endfunction

  pulse_width_timer #(.WidthW(WidthW)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hw_q    <= '0;
      lw_q    <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hw_q    <= hw_d;
      lw_q    <= lw_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    hw_d     = hw_q;
    lw_d     = lw_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (start && enable) begin
          hw_d  = high_width;
          lw_d  = low_width;
          rem_d = pulse_count;
          if (pulse_count != '0) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = width_m1(high_width);
          end else begin
            state_d = DONE;
          end
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          if (rem_q == C_ONE) begin
            state_d = DONE;
          end else begin
            state_d  = LOW;
            rem_d    = rem_q - C_ONE;
            tmr_load = 1'b1;
            tmr_val  = width_m1(lw_q);
          end
        end
      end
      LOW: begin
        if (tmr_zero) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = width_m1(hw_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    out_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign ovr_hit = start && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (ovr_hit) begin
      overrun_q <= 1'b1;
    end else if (overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  // Unlike the sticky flag, a clear beats a same-cycle increment here.
  always_ff @(posedge clk) begin
    if (!reset_n || overrun_clr) begin
      ovr_cnt_q <= '0;
    end else if (ovr_hit) begin
      ovr_cnt_q <= sat_inc(ovr_cnt_q);
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  // Sticky overrun flag only.
`endif

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen
module tb_pulse_train_gen;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        enable;
  logic [15:0] high_width;
  logic [15:0] low_width;
  logic [7:0]  pulse_count;
  logic        overrun_clr;
  logic        out;
  logic        busy;
  logic        done;
  logic        overrun;
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  pulse_train_gen #(.WidthW(16), .CountW(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .enable     (enable),
    .high_width (high_width),
    .low_width  (low_width),
    .pulse_count(pulse_count),
    .overrun_clr(overrun_clr),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [63:0] pat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_burst(input int len, input logic [63:0] pat);
    exp_t e;
    e.len = len;
    e.pat = pat;
    exp_q.push_back(e);
  endtask

  task automatic fire();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL burst_timeout: still busy after %0d cycles, %0d bursts pending", n, exp_q.size());
    end
  endtask

  // Monitor: collects the out waveform over each busy window and checks it on done.
  initial begin : monitor
    int          mlen;
    logic [63:0] mpat;
    logic        after_done;
    exp_t        e;
    mlen       = 0;
    mpat       = '0;
    after_done = 1'b0;
    forever begin
      @(negedge clk);
      if (after_done) chk("busy_after_done", 64'(busy), 64'(0));
      after_done = 1'b0;
      if (busy) begin
        mpat = {mpat[62:0], out};
        mlen++;
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done after %0d cycles, expected no burst", mlen);
          end else begin
            e = exp_q.pop_front();
            chk("burst_len", 64'(mlen), 64'(e.len));
            chk("burst_pattern", mpat, e.pat);
          end
          after_done = 1'b1;
        end
      end else begin
        mlen = 0;
        mpat = '0;
      end
    end
  end

  initial begin : stimulus
    reset_n     = 1'b0;
    start       = 1'b0;
    enable      = 1'b1;
    high_width  = 16'd0;
    low_width   = 16'd0;
    pulse_count = 8'd0;
    overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_out", 64'(out), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_overrun", 64'(overrun), 64'(0));
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
    chk("reset_overrun_cnt", 64'(overrun_cnt), 64'(0));
`endif

    // H=3 L=2 N=3, inputs changed right after accept must not matter
    high_width = 16'd3; low_width = 16'd2; pulse_count = 8'd3;
    expect_burst(14, 64'b11100111001110);
    fire();
    high_width = 16'd9; low_width = 16'd7; pulse_count = 8'd5;
    wait_idle(60);

    // zero widths clamp to one cycle
    high_width = 16'd0; low_width = 16'd0; pulse_count = 8'd2;
    expect_burst(4, 64'b1010);
    fire();
    wait_idle(20);

    // empty burst
    high_width = 16'd3; pulse_count = 8'd0;
    expect_burst(1, 64'b0);
    fire();
    wait_idle(20);

    // start while disabled is ignored
    enable = 1'b0; pulse_count = 8'd1;
    fire();
    @(negedge clk);
    chk("disabled_busy", 64'(busy), 64'(0));
    chk("disabled_overrun", 64'(overrun), 64'(0));
    enable = 1'b1;

    // overrun: extra starts at t0+2 and t0+6 leave the burst unchanged
    high_width = 16'd4; low_width = 16'd3; pulse_count = 8'd2;
    expect_burst(12, 64'b111100011110);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(40);
    chk("overrun_set", 64'(overrun), 64'(1));
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
    chk("overrun_cnt_two", 64'(overrun_cnt), 64'(2));
`endif
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", 64'(overrun), 64'(0));
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
    chk("overrun_cnt_cleared", 64'(overrun_cnt), 64'(0));
`endif

    // overrun_clr together with start-while-busy: flag set wins, counter clear wins
    high_width = 16'd3; low_width = 16'd0; pulse_count = 8'd1;
    expect_burst(4, 64'b1110);
    fire();
    @(posedge clk); #1 start = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1 start = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    chk("overrun_set_wins", 64'(overrun), 64'(1));
`ifdef PULSE_TRAIN_OVERRUN_CNT_EN
    chk("overrun_cnt_clear_wins", 64'(overrun_cnt), 64'(0));
`endif
    wait_idle(20);

    // reset in the middle of HIGH aborts without done
    high_width = 16'd4; low_width = 16'd2; pulse_count = 8'd2;
    fire();
    @(negedge clk);
    chk("pre_abort_busy", 64'(busy), 64'(1));
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_out", 64'(out), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_overrun", 64'(overrun), 64'(0));
    repeat (4) @(negedge clk);

    // normal burst after the abort
    high_width = 16'd2; low_width = 16'd1; pulse_count = 8'd1;
    expect_burst(3, 64'b110);
    fire();
    wait_idle(20);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
